// File: rtl/gpr_file_mp.sv
// gpr_file_mp: multi-port GPR file with two write ports, combinational reads,
// optional same-cycle bypass and a per-register pending-write scoreboard.
`default_nettype none

module gpr_file_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wa_en,
  input  logic [ADDR_W-1:0]        wa_addr,
  input  logic [DATA_W-1:0]        wa_data,
  input  logic                     wb_en,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     sb_set,
  input  logic [ADDR_W-1:0]        sb_addr,
  output logic                     busy_any
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = '0;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;

  logic wa_hit;
  logic wb_hit;
  logic wb_wr;

  assign wa_hit = wa_en && (wa_addr != ZERO_ADDR);
  assign wb_hit = wb_en && (wb_addr != ZERO_ADDR);
  // Port B loses a same-address collision with port A.
  assign wb_wr  = wb_hit && !(wa_hit && (wa_addr == wb_addr));

  always_comb begin
    busy_d = busy_q;
    if (wa_hit) busy_d[wa_addr] = 1'b0;
    if (wb_hit) busy_d[wb_addr] = 1'b0;
    // A newly issued producer outranks the one retiring in the same cycle.
    if (sb_set && (sb_addr != ZERO_ADDR)) busy_d[sb_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        regs_q[k] <= '0;
      end
      busy_q <= '0;
    end else begin
      if (wa_hit) regs_q[wa_addr] <= wa_data;
      if (wb_wr)  regs_q[wb_addr] <= wb_data;
      busy_q <= busy_d;
    end
  end

  assign busy_any = |busy_q;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              busy;

    assign addr = rd_addr[i*ADDR_W +: ADDR_W];

    always_comb begin
      data = regs_q[addr];
      busy = busy_q[addr];
      if (BYPASS != 0) begin
        if (wa_hit && (wa_addr == addr)) begin
          data = wa_data;
          busy = 1'b0;
        end else if (wb_hit && (wb_addr == addr)) begin
          data = wb_data;
          busy = 1'b0;
        end
      end
      // Held reset must not let bypassed write data leak onto the outputs.
      if (!reset || (addr == ZERO_ADDR)) begin
        data = '0;
        busy = 1'b0;
      end
    end

    assign rd_data[i*DATA_W +: DATA_W] = data;
    assign rd_busy[i]                  = busy;
  end

endmodule

`default_nettype wire

// File: tb/tb_gpr_file_mp.sv
// tb_gpr_file_mp: directed checks of gpr_file_mp with a 4-read bypassing
// instance and a 1-read non-bypassing instance sharing the write/scoreboard inputs.
`default_nettype none

module tb_gpr_file_mp;

  logic         clk;
  logic         reset;
  logic [19:0]  rd_addr;
  logic [127:0] rd_data;
  logic [3:0]   rd_busy;
  logic         busy_any;
  logic [4:0]   rd_addr0;
  logic [31:0]  rd_data0;
  logic [0:0]   rd_busy0;
  logic         busy_any0;
  logic         wa_en;
  logic [4:0]   wa_addr;
  logic [31:0]  wa_data;
  logic         wb_en;
  logic [4:0]   wb_addr;
  logic [31:0]  wb_data;
  logic         sb_set;
  logic [4:0]   sb_addr;

  int checks;
  int failures;

  gpr_file_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(4), .BYPASS(1)) dut (
    .clk(clk), .reset(reset),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .sb_set(sb_set), .sb_addr(sb_addr), .busy_any(busy_any)
  );

  gpr_file_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(1), .BYPASS(0)) dut0 (
    .clk(clk), .reset(reset),
    .rd_addr(rd_addr0), .rd_data(rd_data0), .rd_busy(rd_busy0),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .sb_set(sb_set), .sb_addr(sb_addr), .busy_any(busy_any0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    wa_en = 1'b0; wa_addr = '0; wa_data = '0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    sb_set = 1'b0; sb_addr = '0;
  endtask

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1,
                        input logic [4:0] a2, input logic [4:0] a3);
    rd_addr = {a3, a2, a1, a0};
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle();
    set_rd(5'd5, 5'd0, 5'd0, 5'd0);
    rd_addr0 = 5'd5;
    @(negedge clk); #1;
    checks++;
    if (rd_data[31:0] !== 32'h0 || rd_busy !== 4'h0 || busy_any !== 1'b0) begin
      failures++;
      $display("FAIL reset_init: data=%h busy=%b any=%b expected 0/0/0", rd_data[31:0], rd_busy, busy_any);
    end
    reset = 1'b1;
    @(negedge clk);
    wa_en = 1'b1; wa_addr = 5'd5; wa_data = 32'h1234;
    sb_set = 1'b1; sb_addr = 5'd5;
    @(negedge clk);
    idle(); #1;
    checks++;
    if (rd_data[31:0] !== 32'h1234 || rd_busy[0] !== 1'b1 || busy_any !== 1'b1) begin
      failures++;
      $display("FAIL reset_preload: data=%h busy=%b any=%b expected 1234/1/1", rd_data[31:0], rd_busy[0], busy_any);
    end
    @(posedge clk); #2;
    reset = 1'b0; #1;
    checks++;
    if (rd_data[31:0] !== 32'h0 || rd_busy[0] !== 1'b0 || busy_any !== 1'b0 || rd_data0 !== 32'h0) begin
      failures++;
      $display("FAIL reset_async: data=%h busy=%b any=%b data0=%h expected 0/0/0/0", rd_data[31:0], rd_busy[0], busy_any, rd_data0);
    end
    wa_en = 1'b1; wa_addr = 5'd5; wa_data = 32'h9999;
    sb_set = 1'b1; sb_addr = 5'd5;
    @(negedge clk);
    idle();
    reset = 1'b1; #1;
    checks++;
    if (rd_data[31:0] !== 32'h0 || rd_busy[0] !== 1'b0 || busy_any !== 1'b0) begin
      failures++;
      $display("FAIL reset_ignores_write: data=%h busy=%b any=%b expected 0/0/0", rd_data[31:0], rd_busy[0], busy_any);
    end
  endtask

  task automatic test_write_read();
    @(negedge clk);
    wa_en = 1'b1; wa_addr = 5'd3; wa_data = 32'hDEADBEEF;
    set_rd(5'd3, 5'd0, 5'd0, 5'd0);
    rd_addr0 = 5'd3; #1;
    checks++;
    if (rd_data[31:0] !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL wr_bypass: got %h expected deadbeef", rd_data[31:0]);
    end
    checks++;
    if (rd_data0 !== 32'h0) begin
      failures++;
      $display("FAIL wr_nobypass_old: got %h expected 0", rd_data0);
    end
    @(negedge clk);
    idle(); #1;
    checks++;
    if (rd_data[31:0] !== 32'hDEADBEEF || rd_data0 !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL wr_stored: got %h/%h expected deadbeef/deadbeef", rd_data[31:0], rd_data0);
    end
  endtask

  task automatic test_collision();
    @(negedge clk);
    wa_en = 1'b1; wa_addr = 5'd7; wa_data = 32'h1;
    wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h2;
    set_rd(5'd7, 5'd0, 5'd0, 5'd0);
    rd_addr0 = 5'd7; #1;
    checks++;
    if (rd_data[31:0] !== 32'h1) begin
      failures++;
      $display("FAIL coll_bypass: got %h expected 1", rd_data[31:0]);
    end
    @(negedge clk);
    idle(); #1;
    checks++;
    if (rd_data[31:0] !== 32'h1 || rd_data0 !== 32'h1) begin
      failures++;
      $display("FAIL coll_stored: got %h/%h expected 1/1", rd_data[31:0], rd_data0);
    end
    wa_en = 1'b1; wa_addr = 5'd0; wa_data = 32'hFFFF;
    set_rd(5'd0, 5'd0, 5'd0, 5'd0);
    rd_addr0 = 5'd0; #1;
    checks++;
    if (rd_data[31:0] !== 32'h0) begin
      failures++;
      $display("FAIL r0_bypass: got %h expected 0", rd_data[31:0]);
    end
    @(negedge clk);
    idle(); #1;
    checks++;
    if (rd_data[31:0] !== 32'h0 || rd_data0 !== 32'h0) begin
      failures++;
      $display("FAIL r0_stored: got %h/%h expected 0/0", rd_data[31:0], rd_data0);
    end
  endtask

  task automatic test_dual_write();
    @(negedge clk);
    wa_en = 1'b1; wa_addr = 5'd4; wa_data = 32'hA;
    wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'hB;
    set_rd(5'd4, 5'd9, 5'd0, 5'd4);
    rd_addr0 = 5'd9; #1;
    checks++;
    if (rd_data !== {32'hA, 32'h0, 32'hB, 32'hA}) begin
      failures++;
      $display("FAIL dual_bypass: got %h expected a/0/b/a (port3..0)", rd_data);
    end
    @(negedge clk);
    idle(); #1;
    checks++;
    if (rd_data !== {32'hA, 32'h0, 32'hB, 32'hA} || rd_data0 !== 32'hB) begin
      failures++;
      $display("FAIL dual_stored: got %h / %h expected a/0/b/a / b", rd_data, rd_data0);
    end
  endtask

  task automatic test_scoreboard();
    @(negedge clk);
    sb_set = 1'b1; sb_addr = 5'd6;
    set_rd(5'd6, 5'd0, 5'd0, 5'd0);
    rd_addr0 = 5'd6; #1;
    checks++;
    if (rd_busy[0] !== 1'b0 || busy_any !== 1'b0) begin
      failures++;
      $display("FAIL sb_set_same_cycle: busy=%b any=%b expected 0/0", rd_busy[0], busy_any);
    end
    @(negedge clk);
    idle(); #1;
    checks++;
    if (rd_busy[0] !== 1'b1 || busy_any !== 1'b1 || rd_busy0 !== 1'b1) begin
      failures++;
      $display("FAIL sb_set_next: busy=%b any=%b busy0=%b expected 1/1/1", rd_busy[0], busy_any, rd_busy0);
    end
    wb_en = 1'b1; wb_addr = 5'd6; wb_data = 32'h55; #1;
    checks++;
    if (rd_busy[0] !== 1'b0 || rd_data[31:0] !== 32'h55) begin
      failures++;
      $display("FAIL sb_wb_bypass: busy=%b data=%h expected 0/55", rd_busy[0], rd_data[31:0]);
    end
    checks++;
    if (rd_busy0 !== 1'b1 || rd_data0 !== 32'h0) begin
      failures++;
      $display("FAIL sb_wb_nobypass: busy=%b data=%h expected 1/0", rd_busy0, rd_data0);
    end
    @(negedge clk);
    idle(); #1;
    checks++;
    if (rd_busy[0] !== 1'b0 || busy_any !== 1'b0 || rd_data0 !== 32'h55 || rd_busy0 !== 1'b0) begin
      failures++;
      $display("FAIL sb_cleared: busy=%b any=%b data0=%h busy0=%b expected 0/0/55/0", rd_busy[0], busy_any, rd_data0, rd_busy0);
    end
    sb_set = 1'b1; sb_addr = 5'd6;
    wa_en = 1'b1; wa_addr = 5'd6; wa_data = 32'h77; #1;
    checks++;
    if (rd_busy[0] !== 1'b0 || rd_data[31:0] !== 32'h77) begin
      failures++;
      $display("FAIL sb_setclr_bypass: busy=%b data=%h expected 0/77", rd_busy[0], rd_data[31:0]);
    end
    @(negedge clk);
    idle(); #1;
    checks++;
    if (rd_data[31:0] !== 32'h77 || rd_busy[0] !== 1'b1 || busy_any !== 1'b1 || busy_any0 !== 1'b1) begin
      failures++;
      $display("FAIL sb_set_wins: data=%h busy=%b any=%b any0=%b expected 77/1/1/1", rd_data[31:0], rd_busy[0], busy_any, busy_any0);
    end
    wa_en = 1'b1; wa_addr = 5'd6; wa_data = 32'h88;
    @(negedge clk);
    idle(); #1;
    checks++;
    if (busy_any !== 1'b0 || rd_data[31:0] !== 32'h88) begin
      failures++;
      $display("FAIL sb_drain: any=%b data=%h expected 0/88", busy_any, rd_data[31:0]);
    end
  endtask

  task automatic test_zero_sb();
    @(negedge clk);
    sb_set = 1'b1; sb_addr = 5'd0;
    set_rd(5'd0, 5'd0, 5'd0, 5'd0);
    rd_addr0 = 5'd0;
    @(negedge clk);
    idle(); #1;
    checks++;
    if (busy_any !== 1'b0 || rd_busy !== 4'h0 || rd_data[31:0] !== 32'h0) begin
      failures++;
      $display("FAIL zero_sb: any=%b busy=%b data=%h expected 0/0/0", busy_any, rd_busy, rd_data[31:0]);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    wb_en = 1'b1; wb_addr = 5'd10; wb_data = 32'h100;
    set_rd(5'd10, 5'd11, 5'd0, 5'd0);
    @(negedge clk);
    wb_addr = 5'd11; wb_data = 32'h200;
    wa_en = 1'b1; wa_addr = 5'd10; wa_data = 32'h300; #1;
    checks++;
    if (rd_data[63:0] !== {32'h200, 32'h300}) begin
      failures++;
      $display("FAIL b2b_bypass: got %h expected 200/300", rd_data[63:0]);
    end
    @(negedge clk);
    idle(); #1;
    checks++;
    if (rd_data[63:0] !== {32'h200, 32'h300}) begin
      failures++;
      $display("FAIL b2b_stored: got %h expected 200/300", rd_data[63:0]);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_write_read();
    test_collision();
    test_dual_write();
    test_scoreboard();
    test_zero_sb();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
